add_resp_pipe: RTL and testbench



---
 rtl/add_pkg_hdl.sv | 12 +
 rtl/add_resp_fifo.sv | 44 ++++
 rtl/add_resp_pipe.sv | 61 ++++++
 tb/tb_add_resp_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/add_pkg_hdl.sv
// add_pkg_hdl: shared defaults, result record and reference adder for the add environment
package add_pkg_hdl;
  localparam int ADD_WIDTH_DEFAULT = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  typedef struct packed {
    logic [ADD_WIDTH_DEFAULT:0] sum;
    logic [7:0] tag;
  } add_result_t;
  function automatic logic [32:0] add_ref(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/add_resp_fifo.sv
// add_resp_fifo: synchronous result FIFO; when empty the output holds the last popped word
module add_resp_fifo #(
  parameter int width = 5,
  parameter int depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(depth):0] count
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  logic [width-1:0] mem [depth];
  logic [width-1:0] last;
  logic [aw-1:0] wr, rd;
  logic do_pop;
  assign do_pop = pop && !empty;
  assign full = count == cw'(depth);
  assign empty = count == '0;
  assign rdata = empty ? last : mem[rd];
  always_ff @(posedge clk)
    if (push) mem[wr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      last <= '0;
    end else begin
      if (push) wr <= wr + aw'(1);
      if (do_pop) begin
        last <= mem[rd];
        rd <= rd + aw'(1);
      end
      count <= count + cw'(push) - cw'(do_pop);
    end
  always_comb
    if (!rst) assert (!(push && full && !do_pop));
endmodule

// File: rtl/add_resp_pipe.sv
// add_resp_pipe: two-stage adder pipeline feeding a result FIFO, credit-limited so no result is dropped
module add_resp_pipe
  import add_pkg_hdl::*;
#(
  parameter int add_width = ADD_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [add_width-1:0] a,
  input  logic [add_width-1:0] b,
  output logic out_valid,
  input  logic out_ready,
  output logic [add_width:0] sum,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);
  localparam int cw = $clog2(FIFO_DEPTH) + 1;
  logic s1_v, s2_v, accept, pop, full, empty;
  logic [add_width-1:0] s1_a, s1_b;
  logic [add_width:0] s2_sum, next_sum;
  logic [cw-1:0] credits, fifo_count;
  assign in_ready = !rst && (credits < cw'(FIFO_DEPTH));
  assign accept = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign occupancy = credits;
  assign next_sum = {1'b0, s1_a} + {1'b0, s1_b};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s2_sum <= '0;
      credits <= '0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
      if (accept) begin
        s1_a <= a;
        s1_b <= b;
      end
      if (s1_v) s2_sum <= next_sum;
      credits <= credits + cw'(accept) - cw'(pop);
    end
  add_resp_fifo #(.width(add_width + 1), .depth(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(s2_v), .pop(pop), .wdata(s2_sum),
    .rdata(sum), .full(full), .empty(empty), .count(fifo_count)
  );
  // every credit is either in a pipeline stage or sitting in the FIFO
  always_comb
    if (!rst) begin
      assert (credits <= cw'(FIFO_DEPTH));
      assert (credits == cw'(s1_v) + cw'(s2_v) + fifo_count);
      assert (!(full && s2_v && !pop));
      if (s1_v) assert (33'(next_sum) == add_ref(32'(s1_a), 32'(s1_b)));
    end
  assert property (@(posedge clk) disable iff (rst) out_valid && !out_ready |=> out_valid && $stable(sum));
endmodule

// File: tb/tb_add_resp_pipe.sv
// tb_add_resp_pipe: directed checks of latency, backpressure, streaming, reset flush and stall hold
module tb_add_resp_pipe;
  import add_pkg_hdl::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
  logic [3:0] a = '0, b = '0;
  logic [4:0] sum;
  logic [2:0] occupancy;
  int passed = 0, total = 0;
  logic [3:0] ta [16] = '{4'h0, 4'h1, 4'hF, 4'h7, 4'h8, 4'hA, 4'h3, 4'hC, 4'h5, 4'hE, 4'h9, 4'h2, 4'hB, 4'h6, 4'hD, 4'h4};
  logic [3:0] tv [16] = '{4'h0, 4'hF, 4'hF, 4'h9, 4'h8, 4'h6, 4'hD, 4'h4, 4'h2, 4'hB, 4'h1, 4'h7, 4'h5, 4'hA, 4'h3, 4'hC};
  add_result_t q [$];

  add_resp_pipe #(.add_width(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n_in, n_out, stale;
    logic over;
    logic [4:0] exp_d [4];
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_occ", occupancy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    // single op: 0xF + 0x1
    in_valid = 1'b1; a = 4'hF; b = 4'h1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_occ1", occupancy, 1);
    chk("single_ov_e0", out_valid, 0);
    tick();
    chk("single_ov_e1", out_valid, 0);
    tick();
    chk("single_ov_e2", out_valid, 1);
    chk("single_sum", sum, 5'h10);
    tick();
    chk("single_ov_after", out_valid, 0);
    chk("single_sum_hold", sum, 5'h10);
    chk("single_occ0", occupancy, 0);
    // backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 4'(2 * i + 1); b = 4'(2 * i + 2);
      tick();
    end
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_occ_full", occupancy, 4);
    a = 4'h9; b = 4'h9;
    repeat (2) tick();
    chk("bp_still_blocked", in_ready, 0);
    chk("bp_head_valid", out_valid, 1);
    chk("bp_head_sum", sum, 5'h03);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_occ_after_pop", occupancy, 3);
    chk("bp_next_head", sum, 5'h07);
    tick();
    in_valid = 1'b0;
    chk("bp_99_accepted_occ", occupancy, 4);
    chk("bp_99_in_ready", in_ready, 0);
    exp_d = '{5'h07, 5'h0B, 5'h0F, 5'h12};
    out_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 20 && n_out < 4; c++) begin
      if (out_valid) begin
        chk("bp_drain_sum", sum, exp_d[n_out]);
        n_out++;
      end
      tick();
    end
    chk("bp_drain_count", n_out, 4);
    // back-to-back streaming
    in_valid = 1'b1; a = ta[0]; b = tv[0];
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("stream_ov", out_valid, (i >= 2 && i <= 17) ? 1 : 0);
      if (out_valid && i >= 2 && i <= 17)
        chk("stream_sum", sum, add_ref(32'(ta[i-2]), 32'(tv[i-2])));
      chk("stream_occ_le4", occupancy <= 3'd4, 1);
      if (i < 15) chk("stream_in_ready", in_ready, 1);
      in_valid = i + 1 < 16;
      a = ta[(i + 1) % 16]; b = tv[(i + 1) % 16];
    end
    chk("stream_empty_occ", occupancy, 0);
    // toggling out_ready with continuous input
    n_in = 0; n_out = 0; over = 1'b0;
    in_valid = 1'b1; a = ta[0]; b = tv[15]; out_ready = 1'b1;
    for (int c = 0; c < 200 && n_out < 12; c++) begin
      if (occupancy > 3'd4) over = 1'b1;
      if (in_valid && in_ready) begin
        q.push_back('{sum: 5'(add_ref(32'(a), 32'(b))), tag: 8'(n_in)});
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("toggle_dup", 1, 0);
        else begin
          chk("toggle_sum", sum, q[0].sum);
          void'(q.pop_front());
        end
        n_out++;
      end
      tick();
      out_ready = ~out_ready;
      in_valid = n_in < 12;
      a = ta[n_in % 16]; b = tv[15 - (n_in % 16)];
    end
    chk("toggle_count", n_out, 12);
    chk("toggle_no_overflow", over, 0);
    chk("toggle_queue_empty", q.size(), 0);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    // asynchronous reset with 3 stored and 1 in flight
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 4'(i + 4); b = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mid_ov_before_rst", out_valid, 1);
    chk("mid_occ_before_rst", occupancy, 4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_sum", sum, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_release_ready", in_ready, 1);
    in_valid = 1'b1; a = 4'h2; b = 4'h3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        chk("mid_only_sum", sum, 5'h05);
        stale++;
      end
      tick();
    end
    chk("mid_result_count", stale, 1);
    // stall stability
    out_ready = 1'b0;
    in_valid = 1'b1; a = 4'hF; b = 4'hF;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    for (int c = 0; c < 5; c++) begin
      chk("stall_ov", out_valid, 1);
      chk("stall_sum", sum, 5'h1E);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall_popped", out_valid, 0);
    chk("stall_sum_hold", sum, 5'h1E);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
